temp_duty_ctrl: RTL and testbench
=================================

# temp_duty_ctrl

Proportional duty-cycle controller that sits directly upstream of the PWM generator. It accepts temperature samples over a valid/ready handshake and computes an on-time from the setpoint error. It drives the PWM's enable, on-time and period inputs, and loads a new on-time only at the PWM period boundary, using the PWM's `cnt_val` output. It also watches the PWM's free-running `milli_cnt` for a sample timeout, and latches over-temperature and timeout faults that force the heater off.

## Interface
- `TW`, 12: temperature/setpoint width, unsigned.
- `PERIOD`, 100000: PWM period value driven on `pwm_tp`.
- `KP`, 16'd40: proportional gain, unsigned 16-bit.
- `MIN_ON`, 500: computed on-times below this become 0.
- `T_MAX`, 12'd1600: over-temperature threshold.
- `TIMEOUT_MS`, 250: maximum ms ticks allowed between accepted samples.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl_en`  in  1  control enable, level.
- `fault_clr`  in  1  single-cycle fault clear.
- `setpoint`  in  TW  target temperature.
- `temp_valid`  in  1  sample valid.
- `temp_data`  in  TW  sample value.
- `temp_ready`  out  1  sample accept.
- `cnt_val`  in  32  PWM period counter.
- `milli_cnt`  in  32  PWM millisecond counter.
- `pwm_en`  out  1  PWM enable.
- `pwm_ton`  out  32  PWM on-time.
- `pwm_tp`  out  32  PWM period, constant `PERIOD`.
- `fault`  out  1  fault latched.
- `fault_code`  out  2  fault cause: 01 over-temperature, 10 timeout, 00 none.

## Operation
- States:
  - IDLE: `pwm_en`=0, `pwm_ton`=0, `temp_ready`=1, samples discarded. Goes to RUN when `ctrl_en`=1.
  - RUN: `pwm_en`=1, `temp_ready`=1. On a sample transfer (`temp_valid`&`temp_ready`), goes to CALC1.
  - CALC1: registers err = `setpoint` − `temp_data` (signed, TW+1 bits). Goes to CALC2.
  - CALC2: registers `ton_next`. Goes to PEND.
  - PEND: `temp_ready`=0. In the cycle where `cnt_val`==`PERIOD`, `pwm_ton` ← `ton_next` and the state returns to RUN.
  - FAULT: `pwm_en`=0, `pwm_ton`=0, `fault`=1, `temp_ready`=1, samples discarded. Leaves only on `fault_clr`=1, going to IDLE.
- `temp_ready`=0 in CALC1, CALC2 and PEND; `temp_valid` held during these states is accepted only after returning to RUN.
- Arithmetic:
  - If err ≤ 0, `ton_next`=0.
  - Otherwise prod = err × `KP` (unsigned, 32 bits), `ton_next` = min(prod, `PERIOD`).
  - If `ton_next` < `MIN_ON`, `ton_next`=0.
- Over-temperature: a transferred sample with `temp_data` ≥ `T_MAX` → FAULT with `fault_code`=01. The sample is not used for computation.
- Timeout:
  - ms tick = `milli_cnt` ≠ its value registered one cycle earlier.
  - The tick counter clears on each sample transfer and on entering RUN from IDLE, and counts ticks in RUN/CALC1/CALC2/PEND.
  - When it reaches `TIMEOUT_MS`: FAULT with `fault_code`=10.
- Priority, highest first: `rst_n` > over-temperature > timeout > `ctrl_en`=0 > normal flow.
- `ctrl_en`=0 in any non-FAULT state → IDLE on the next edge; any pending `ton_next` is discarded.
- `fault_code` holds its value until `fault_clr`, which clears `fault` and `fault_code` to 0.

## Timing
- Reset values: `pwm_en`=0, `pwm_ton`=0, `pwm_tp`=`PERIOD`, `temp_ready`=1, `fault`=0, `fault_code`=00, state IDLE, timeout count 0.
- Reset assertion takes effect immediately (asynchronous), including mid-computation or mid-PEND.
- Latency, for a sample transferred at edge N:
  - CALC1 during cycle N+1, CALC2 during N+2, PEND from N+3.
  - `pwm_ton` changes at the first edge ≥ N+3 whose preceding cycle had `cnt_val`==`PERIOD`. The PWM therefore samples the new on-time from `cnt_val`=0.
- `pwm_ton` never changes mid-period, except when forced to 0 on entering FAULT or IDLE; that takes effect on the next edge.
- Over-temperature fault: `pwm_en`/`pwm_ton` are 0 one edge after the offending transfer.

## Test plan
Parameters for all scenarios: `PERIOD`=1000, `KP`=10, `MIN_ON`=20, `T_MAX`=1600, `TIMEOUT_MS`=4, `setpoint`=800.
- **Normal update:** `temp_data`=750 → `pwm_ton` stays 0 until `cnt_val`=1000, then becomes 500 on the next edge; `pwm_en`=1.
- **Clamping and minimum on-time:**
  - 700 → 1000 (clamped).
  - 810 → 0.
  - 799 → 0 (10 < `MIN_ON`).
  - 798 → 20.
- **Over-temperature:** sample 1600 → next edge `fault`=1, `fault_code`=01, `pwm_en`=0, `pwm_ton`=0. Further samples are ignored; `fault_clr` → IDLE, then RUN on the following edge with `ctrl_en`=1.
- **Timeout:** no sample for 4 `milli_cnt` increments while in RUN → `fault_code`=10. A sample arriving at 3 ticks resets the count and no fault occurs.
- **Backpressure:** hold `temp_valid`=1 with `temp_data`=750, then 700 → `temp_ready`=0 through CALC1/CALC2/PEND. The second value is accepted only after the boundary load, and `pwm_ton` reaches 1000 one period later.
- **Abort and reset:**
  - `ctrl_en`=0 during PEND → IDLE next edge, `pwm_ton`=0, and the pending value is never loaded.
  - `rst_n`=0 mid-CALC2 → all outputs immediately at their reset values.

Source files
------------

// File: rtl/temp_duty_ctrl.sv
// rtl/temp_duty_ctrl.sv - proportional heater duty controller feeding the PWM generator
// Loads new on-times only at the PWM period boundary; latches over-temperature and timeout faults.
module temp_duty_ctrl #(
   parameter int            TW         = 12,
   parameter int            PERIOD     = 100000,
   parameter logic [15:0]   KP         = 16'd40,
   parameter int            MIN_ON     = 500,
   parameter logic [TW-1:0] T_MAX      = 12'd1600,
   parameter int            TIMEOUT_MS = 250
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ctrl_en,
   input  logic          fault_clr,
   input  logic [TW-1:0] setpoint,
   input  logic          temp_valid,
   input  logic [TW-1:0] temp_data,
   output logic          temp_ready,
   input  logic [31:0]   cnt_val,
   input  logic [31:0]   milli_cnt,
   output logic          pwm_en,
   output logic [31:0]   pwm_ton,
   output logic [31:0]   pwm_tp,
   output logic          fault,
   output logic [1:0]    fault_code
);

   localparam int CW = $clog2(TIMEOUT_MS + 1);

   typedef enum logic [2:0] {IDLE, RUN, CALC1, CALC2, PEND, FAULT} state_t;

   state_t           state, state_nxt;
   logic [TW-1:0]    sample_q;
   logic signed [TW:0] err_q;
   logic [31:0]      ton_next_q;
   logic [31:0]      ton_calc;
   logic [31:0]      prod;
   logic [31:0]      milli_q;
   logic [CW-1:0]    tick_cnt;
   logic [1:0]       code_q, code_nxt;
   logic             xfer, tick, active, over_temp, timed_out;
   logic             load_ton, clr_ton;

   assign xfer       = temp_valid & temp_ready;
   assign tick       = (milli_cnt != milli_q);
   assign active     = (state == RUN) || (state == CALC1) || (state == CALC2) || (state == PEND);
   assign over_temp  = (state == RUN) && xfer && (temp_data >= T_MAX);
   assign timed_out  = active && (tick_cnt == CW'(TIMEOUT_MS));

   assign temp_ready = !((state == CALC1) || (state == CALC2) || (state == PEND));
   assign pwm_en     = active;
   assign pwm_tp     = 32'(PERIOD);
   assign fault      = (state == FAULT);
   assign fault_code = code_q;

   always_comb begin
      state_nxt = state;
      code_nxt  = code_q;
      load_ton  = 1'b0;
      clr_ton   = 1'b0;
      if (over_temp) begin
         state_nxt = FAULT;
         code_nxt  = 2'b01;
         clr_ton   = 1'b1;
      end else if (timed_out) begin
         state_nxt = FAULT;
         code_nxt  = 2'b10;
         clr_ton   = 1'b1;
      end else if (!ctrl_en && (state != FAULT)) begin
         state_nxt = IDLE;
         clr_ton   = 1'b1;
      end else begin
         case (state)
            IDLE:    if (ctrl_en) state_nxt = RUN;
            RUN:     if (xfer) state_nxt = CALC1;
            CALC1:   state_nxt = CALC2;
            CALC2:   state_nxt = PEND;
            PEND: begin
               if (cnt_val == 32'(PERIOD)) begin
                  load_ton  = 1'b1;
                  state_nxt = RUN;
               end
            end
            FAULT: begin
               if (fault_clr) begin
                  state_nxt = IDLE;
                  code_nxt  = 2'b00;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Positive error only; the magnitude fits TW bits when the sign bit is clear.
   always_comb begin
      prod     = 32'(err_q[TW-1:0]) * 32'(KP);
      ton_calc = '0;
      if (!err_q[TW] && (err_q != '0)) begin
         ton_calc = (prod > 32'(PERIOD)) ? 32'(PERIOD) : prod;
         if (ton_calc < 32'(MIN_ON)) ton_calc = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_q   <= '0;
         err_q      <= '0;
         ton_next_q <= '0;
         pwm_ton    <= '0;
         code_q     <= '0;
         milli_q    <= '0;
         tick_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         code_q  <= code_nxt;
         milli_q <= milli_cnt;
         if (xfer) sample_q <= temp_data;
         if (state == CALC1) err_q <= $signed({1'b0, setpoint}) - $signed({1'b0, sample_q});
         if (state == CALC2) ton_next_q <= ton_calc;
         if (clr_ton) pwm_ton <= '0;
         else if (load_ton) pwm_ton <= ton_next_q;
         if (xfer || ((state == IDLE) && (state_nxt == RUN))) tick_cnt <= '0;
         else if (active && tick && !timed_out) tick_cnt <= tick_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_temp_duty_ctrl.sv
// tb/tb_temp_duty_ctrl.sv - randomized self-checking bench for temp_duty_ctrl
// Drives a stepping PWM counter and checks on-time loads against an arithmetic reference.
module tb_temp_duty_ctrl;

   localparam int P_PERIOD = 1000;
   localparam int P_KP     = 10;
   localparam int P_MIN_ON = 20;
   localparam int P_STEP   = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ctrl_en;
   logic        fault_clr;
   logic [11:0] setpoint;
   logic        temp_valid;
   logic [11:0] temp_data;
   logic        temp_ready;
   logic [31:0] cnt_val = '0;
   logic [31:0] milli_cnt;
   logic        pwm_en;
   logic [31:0] pwm_ton;
   logic [31:0] pwm_tp;
   logic        fault;
   logic [1:0]  fault_code;

   int n_checks = 0;
   int n_errors = 0;
   int mdl_ton  = 0;

   temp_duty_ctrl #(
      .TW(12), .PERIOD(P_PERIOD), .KP(16'd10), .MIN_ON(P_MIN_ON),
      .T_MAX(12'd1600), .TIMEOUT_MS(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .fault_clr(fault_clr),
      .setpoint(setpoint), .temp_valid(temp_valid), .temp_data(temp_data),
      .temp_ready(temp_ready), .cnt_val(cnt_val), .milli_cnt(milli_cnt),
      .pwm_en(pwm_en), .pwm_ton(pwm_ton), .pwm_tp(pwm_tp),
      .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   // Stand-in for the PWM period counter: 0, 50, ..., 1000, 0, ...
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cnt_val = (cnt_val >= 32'(P_PERIOD)) ? 32'd0 : cnt_val + 32'(P_STEP);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_ton(input int sp, input int t);
      int e, p;
      e = sp - t;
      if (e <= 0) return 0;
      p = e * P_KP;
      if (p > P_PERIOD) p = P_PERIOD;
      if (p < P_MIN_ON) p = 0;
      return p;
   endfunction

   // Transfer one sample, then follow it cycle by cycle until the boundary load.
   task automatic run_sample(input int t, input bit hold_next, input int next_t);
      int  exp_ton, cnt_prev, e;
      bit  done;
      exp_ton    = ref_ton(int'(setpoint), t);
      temp_data  = 12'(t);
      temp_valid = 1'b1;
      e = 0;
      @(negedge clk);
      while (!temp_ready && e < 100) begin
         @(negedge clk);
         e++;
      end
      chk("ready_wait", 32'(e < 100), 1);
      @(posedge clk);
      #1;
      if (!hold_next) temp_valid = 1'b0;
      e    = 0;
      done = 1'b0;
      while (!done && e < 100) begin
         @(negedge clk);
         chk("ready_low", temp_ready, 0);
         chk("ton_hold", pwm_ton, mdl_ton);
         chk("en_run", pwm_en, 1);
         cnt_prev = int'(cnt_val);
         @(posedge clk);
         e++;
         #1;
         if (hold_next && e == 1) temp_data = 12'(next_t);
         if (e >= 3 && cnt_prev == P_PERIOD) done = 1'b1;
      end
      chk("load_seen", 32'(done), 1);
      mdl_ton = exp_ton;
      chk("ton_load", pwm_ton, mdl_ton);
      chk("ready_back", temp_ready, 1);
   endtask

   task automatic ms_tick();
      @(posedge clk);
      #1;
      milli_cnt = milli_cnt + 32'd1;
      repeat (2) @(posedge clk);
   endtask

   task automatic clear_fault();
      temp_valid = 1'b0;
      @(posedge clk);
      #1;
      fault_clr = 1'b1;
      @(posedge clk);
      #1;
      fault_clr = 1'b0;
      chk("clr_fault", fault, 0);
      chk("clr_code", fault_code, 0);
      chk("clr_idle_en", pwm_en, 0);
      @(posedge clk);
      #1;
      chk("clr_run_en", pwm_en, 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      ctrl_en    = 1'b0;
      fault_clr  = 1'b0;
      setpoint   = 12'd800;
      temp_valid = 1'b0;
      temp_data  = '0;
      milli_cnt  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_en", pwm_en, 0);
      chk("rst_ton", pwm_ton, 0);
      chk("rst_tp", pwm_tp, 32'(P_PERIOD));
      chk("rst_ready", temp_ready, 1);
      chk("rst_fault", fault, 0);
      chk("rst_code", fault_code, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_en", pwm_en, 0);
      ctrl_en = 1'b1;
      @(posedge clk);
      #1;
      chk("run_en", pwm_en, 1);

      // Directed values, including clamp, MIN_ON edge and just below T_MAX.
      run_sample(750, 0, 0);
      chk("dir_750", pwm_ton, 500);
      run_sample(700, 0, 0);
      chk("dir_700", pwm_ton, 1000);
      run_sample(810, 0, 0);
      run_sample(799, 0, 0);
      run_sample(798, 0, 0);
      chk("dir_798", pwm_ton, 20);
      run_sample(1599, 0, 0);
      chk("no_fault_1599", fault, 0);

      // Backpressure: valid stays high, second value waits for the boundary load.
      run_sample(750, 1, 700);
      run_sample(700, 0, 0);
      chk("bp_second", pwm_ton, 1000);

      // Over-temperature.
      temp_data  = 12'd1600;
      temp_valid = 1'b1;
      @(negedge clk);
      chk("ot_ready", temp_ready, 1);
      @(posedge clk);
      #1;
      mdl_ton = 0;
      chk("ot_fault", fault, 1);
      chk("ot_code", fault_code, 1);
      chk("ot_en", pwm_en, 0);
      chk("ot_ton", pwm_ton, mdl_ton);
      temp_data = 12'd700;
      repeat (30) @(posedge clk);
      #1;
      chk("ot_hold_fault", fault, 1);
      chk("ot_hold_code", fault_code, 1);
      chk("ot_hold_ton", pwm_ton, 0);
      chk("ot_hold_ready", temp_ready, 1);
      clear_fault();

      // Timeout: three ticks are tolerated, a sample restarts the count.
      repeat (3) ms_tick();
      repeat (5) @(posedge clk);
      #1;
      chk("to_3_ticks", fault, 0);
      run_sample(750, 0, 0);
      repeat (3) ms_tick();
      repeat (5) @(posedge clk);
      #1;
      chk("to_3_after_sample", fault, 0);
      ms_tick();
      repeat (2) @(posedge clk);
      #1;
      mdl_ton = 0;
      chk("to_fault", fault, 1);
      chk("to_code", fault_code, 2);
      chk("to_en", pwm_en, 0);
      chk("to_ton", pwm_ton, mdl_ton);
      clear_fault();

      // Randomized samples around a random setpoint.
      for (int i = 0; i < 20; i++) begin
         int sp, t;
         sp = int'($urandom_range(200, 1400));
         t  = sp + int'($urandom_range(0, 250)) - 150;
         if (t < 0) t = 0;
         if (t > 1599) t = 1599;
         setpoint = 12'(sp);
         run_sample(t, 0, 0);
      end
      setpoint = 12'd800;

      // Abort during PEND.
      run_sample(700, 0, 0);
      begin
         int w;
         w = 0;
         @(negedge clk);
         while (cnt_val != 32'd100 && w < 50) begin
            @(negedge clk);
            w++;
         end
         chk("abort_sync", 32'(w < 50), 1);
      end
      temp_data  = 12'd750;
      temp_valid = 1'b1;
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_pend_ready", temp_ready, 0);
      ctrl_en = 1'b0;
      @(posedge clk);
      #1;
      mdl_ton = 0;
      chk("abort_ton", pwm_ton, mdl_ton);
      chk("abort_en", pwm_en, 0);
      ctrl_en = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("abort_noload", pwm_ton, 0);
      chk("abort_run_en", pwm_en, 1);

      // Asynchronous reset during CALC2.
      run_sample(700, 0, 0);
      temp_data  = 12'd750;
      temp_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      mdl_ton = 0;
      chk("arst_en", pwm_en, 0);
      chk("arst_ton", pwm_ton, mdl_ton);
      chk("arst_ready", temp_ready, 1);
      chk("arst_fault", fault, 0);
      chk("arst_code", fault_code, 0);
      chk("arst_tp", pwm_tp, 32'(P_PERIOD));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_run", pwm_en, 1);
      repeat (30) @(posedge clk);
      #1;
      chk("arst_noload", pwm_ton, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
